// File: rtl/frame_pair_diff_pkg.sv
// Shared video definitions for the frame pair differencer: read-back FSM
// encoding, skip-frame range and stage-1 control bundle.
package frame_pair_diff_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_PRIME = 2'd1;
  localparam fsm_state_t ST_RUN   = 2'd2;

  localparam int SKIP_MIN   = 1;
  localparam int SKIP_MAX   = 15;
  localparam int SKIP_CNT_W = 4;

  // Control bits captured alongside the current pixel so they line up with pix_prev
  typedef struct packed {
    logic clken;
    logic vsync;
    logic hsync;
    logic run;
    logic fend;
  } s1_ctrl_t;

  function automatic int clamp_skip(input int n);
    if (n < SKIP_MIN) begin
      return SKIP_MIN;
    end else if (n > SKIP_MAX) begin
      return SKIP_MAX;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/frame_pair_diff_ctrl.sv
// Read-back controller: detects frame ends on ivsync and sequences
// IDLE -> PRIME -> RUN once SKIP_FRAMES complete frames are in SDRAM.
module frame_rd_ctrl
  import frame_pair_diff_pkg::*;
#(
  parameter int SKIP_FRAMES = 1
) (
  input  logic clk,
  input  logic resetb,
  input  logic ivsync,
  input  logic sync_clr,
  output logic run,
  output logic frame_end
);

  localparam logic [SKIP_CNT_W-1:0] SKIP_N  = SKIP_CNT_W'(clamp_skip(SKIP_FRAMES));
  localparam logic [SKIP_CNT_W-1:0] CNT_ONE = {{(SKIP_CNT_W-1){1'b0}}, 1'b1};

  fsm_state_t            state_q;
  fsm_state_t            state_d;
  logic [SKIP_CNT_W-1:0] prime_cnt_q;
  logic [SKIP_CNT_W-1:0] prime_cnt_d;
  logic                  ivsync_q;

  assign frame_end = ivsync_q & ~ivsync;
  assign run       = (state_q == ST_RUN);

  // Next-state logic; a restart pulse overrides any coincident frame end
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    if (sync_clr) begin
      state_d     = ST_IDLE;
      prime_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_end) begin
            state_d     = ST_PRIME;
            prime_cnt_d = '0;
          end else begin
            state_d     = ST_IDLE;
          end
        end
        ST_PRIME: begin
          if (frame_end) begin
            if ((prime_cnt_q + CNT_ONE) == SKIP_N) begin
              state_d     = ST_RUN;
              prime_cnt_d = '0;
            end else begin
              state_d     = ST_PRIME;
              prime_cnt_d = prime_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_PRIME;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d     = ST_IDLE;
          prime_cnt_d = '0;
        end
      endcase
    end
  end

  // State, frame count and vsync history registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      prime_cnt_q <= '0;
      ivsync_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      ivsync_q    <= ivsync;
    end
  end

endmodule

// File: rtl/frame_pair_diff.sv
// Two-stage pixel pair pipeline: pairs the live pixel with its SDRAM copy
// from the previous frame, flags motion and counts moving pixels per frame.
module frame_pair_diff
  import frame_pair_diff_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int SKIP_FRAMES = 1,
  parameter int CNT_W       = 19
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 clken,
  input  logic                 ivsync,
  input  logic                 ihsync,
  input  logic [PIX_W-1:0]     pix_cur,
  input  logic [PIX_W-1:0]     pix_prev,
  input  logic [PIX_W-1:0]     thresh,
  input  logic                 diff_en,
  input  logic                 sync_clr,
  output logic                 oe,
  output logic                 ovsync,
  output logic                 ohsync,
  output logic [2*PIX_W-1:0]   opair,
  output logic [PIX_W-1:0]     odiff,
  output logic                 omotion,
  output logic                 sdr_rd,
  output logic                 sdr_nwr,
  output logic [CNT_W-1:0]     frame_motion,
  output logic                 frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic run_s;
  logic frame_end_s;

  frame_rd_ctrl #(
    .SKIP_FRAMES(SKIP_FRAMES)
  ) u_rd_ctrl (
    .clk       (clk),
    .resetb    (resetb),
    .ivsync    (ivsync),
    .sync_clr  (sync_clr),
    .run       (run_s),
    .frame_end (frame_end_s)
  );

  assign sdr_rd  = run_s & clken;
  assign sdr_nwr = run_s;

  logic [PIX_W-1:0]   s1_pix_q;
  s1_ctrl_t           s1_q;
  s1_ctrl_t           s1_d;

  logic               oe_q, oe_d;
  logic               ovsync_q, ovsync_d;
  logic               ohsync_q, ohsync_d;
  logic [2*PIX_W-1:0] opair_q, opair_d;
  logic [PIX_W-1:0]   odiff_q, odiff_d;
  logic               omotion_q, omotion_d;
  logic [CNT_W-1:0]   mot_cnt_q, mot_cnt_d;
  logic [CNT_W-1:0]   frame_motion_q, frame_motion_d;
  logic               frame_done_q, frame_done_d;

  logic               valid_s;
  logic               gate_s;
  logic [PIX_W-1:0]   diff_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // Stage-1 control bundle assembly
  always_comb begin
    s1_d       = '0;
    s1_d.clken = clken;
    s1_d.vsync = ivsync;
    s1_d.hsync = ihsync;
    s1_d.run   = run_s;
    s1_d.fend  = frame_end_s;
  end

  // Stage 1: delay the live side by one cycle to meet the SDRAM read data
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_pix_q <= '0;
      s1_q     <= '0;
    end else begin
      s1_pix_q <= pix_cur;
      s1_q     <= s1_d;
    end
  end

  assign valid_s = s1_q.clken & s1_q.vsync & s1_q.hsync;
  assign gate_s  = s1_q.run & diff_en & valid_s;
  assign diff_s  = (s1_pix_q >= pix_prev) ? (s1_pix_q - pix_prev) : (pix_prev - s1_pix_q);

  // Stage-2 next values; the stage-1 frame end is exactly the ovsync fall
  always_comb begin
    oe_d      = valid_s;
    ovsync_d  = s1_q.vsync;
    ohsync_d  = s1_q.hsync;
    opair_d   = s1_q.run ? {s1_pix_q, pix_prev} : '0;
    odiff_d   = gate_s ? diff_s : '0;
    omotion_d = gate_s & (diff_s > thresh);
    cnt_inc_s = (omotion_q && (mot_cnt_q != CNT_MAX)) ? (mot_cnt_q + CNT_ONE) : mot_cnt_q;
    if (s1_q.fend) begin
      frame_motion_d = cnt_inc_s;
      frame_done_d   = 1'b1;
    end else begin
      frame_motion_d = frame_motion_q;
      frame_done_d   = 1'b0;
    end
    mot_cnt_d = (sync_clr || s1_q.fend) ? '0 : cnt_inc_s;
  end

  // Stage 2: registered outputs and per-frame motion accounting
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      oe_q           <= 1'b0;
      ovsync_q       <= 1'b0;
      ohsync_q       <= 1'b0;
      opair_q        <= '0;
      odiff_q        <= '0;
      omotion_q      <= 1'b0;
      mot_cnt_q      <= '0;
      frame_motion_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      oe_q           <= oe_d;
      ovsync_q       <= ovsync_d;
      ohsync_q       <= ohsync_d;
      opair_q        <= opair_d;
      odiff_q        <= odiff_d;
      omotion_q      <= omotion_d;
      mot_cnt_q      <= mot_cnt_d;
      frame_motion_q <= frame_motion_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign oe           = oe_q;
  assign ovsync       = ovsync_q;
  assign ohsync       = ohsync_q;
  assign opair        = opair_q;
  assign odiff        = odiff_q;
  assign omotion      = omotion_q;
  assign frame_motion = frame_motion_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_frame_pair_diff.sv
// Self-checking bench for frame_pair_diff: scoreboarded per-cycle model,
// a table of difference/threshold vectors and directed frame sequences.
module tb_frame_pair_diff;

  logic        clk;
  logic        resetb;
  logic        clken, ivsync, ihsync, diff_en, sync_clr;
  logic [7:0]  pix_cur, pix_prev, thresh;
  logic        oe, ovsync, ohsync, omotion, sdr_rd, sdr_nwr, frame_done;
  logic [15:0] opair;
  logic [7:0]  odiff;
  logic [3:0]  frame_motion;

  frame_pair_diff #(.PIX_W(8), .SKIP_FRAMES(1), .CNT_W(4)) dut (
    .clk(clk), .resetb(resetb), .clken(clken), .ivsync(ivsync), .ihsync(ihsync),
    .pix_cur(pix_cur), .pix_prev(pix_prev), .thresh(thresh), .diff_en(diff_en),
    .sync_clr(sync_clr), .oe(oe), .ovsync(ovsync), .ohsync(ohsync), .opair(opair),
    .odiff(odiff), .omotion(omotion), .sdr_rd(sdr_rd), .sdr_nwr(sdr_nwr),
    .frame_motion(frame_motion), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clken, ivs, ihs, den, sclr, run;
    logic [7:0] cur, prev, thr;
  } stim_t;

  typedef struct {
    logic       oe, ovs, ohs, om, done;
    logic [15:0] pair;
    logic [7:0]  diff;
    logic [3:0]  fm;
  } exp_t;

  typedef struct {
    logic [7:0]  cur, prev, thr;
    logic        den;
    logic [7:0]  e_diff;
    logic        e_om;
    logic [15:0] e_pair;
  } vec_t;

  exp_t  sb_q[$];
  stim_t prev_stim;
  int    checks = 0;
  int    errors = 0;

  // reference model state
  int    fe_cnt, cnt_m, fm_m;
  logic  m_prev_ivs, last_om, last_ovs;

  // bookkeeping for directed checks
  int    cyc = 0, frame_idx = 0, first_rd_frame = 0, fe_total = 0;
  int    fe2_cyc = -1, nwr_rise_cyc = -1, done_cnt = 0, rd_hi_cnt = 0;
  logic  prev_smp_nwr = 1'b0;
  logic [3:0] fm_at_done = 4'd0;
  logic [7:0] g_thr = 8'h20;
  logic       g_den = 1'b1;

  logic        smp_oe, smp_om, smp_done, smp_rd, smp_nwr;
  logic [15:0] smp_pair;
  logic [7:0]  smp_diff;
  logic [3:0]  smp_fm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '{oe: 1'b0, ovs: 1'b0, ohs: 1'b0, om: 1'b0, done: 1'b0, pair: 16'h0, diff: 8'h0, fm: 4'h0};
    sb_q.delete();
    sb_q.push_back(z);
    prev_stim = '{clken: 1'b0, ivs: 1'b0, ihs: 1'b0, den: 1'b0, sclr: 1'b0, run: 1'b0,
                  cur: 8'h0, prev: 8'h0, thr: 8'h0};
    fe_cnt = 0; cnt_m = 0; fm_m = 0;
    m_prev_ivs = 1'b0; last_om = 1'b0; last_ovs = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_oe"}, oe, 0);          chk({tag, "_ovsync"}, ovsync, 0);
    chk({tag, "_ohsync"}, ohsync, 0);  chk({tag, "_opair"}, opair, 0);
    chk({tag, "_odiff"}, odiff, 0);    chk({tag, "_omotion"}, omotion, 0);
    chk({tag, "_sdr_rd"}, sdr_rd, 0);  chk({tag, "_sdr_nwr"}, sdr_nwr, 0);
    chk({tag, "_fm"}, frame_motion, 0); chk({tag, "_done"}, frame_done, 0);
  endtask

  // One clock cycle: drive, sample at negedge, score, advance the model.
  task automatic run_cycle(input stim_t s);
    exp_t e, ne;
    logic run_k, valid;
    int   d, inc;
    clken = s.clken; ivsync = s.ivs; ihsync = s.ihs; pix_cur = s.cur;
    pix_prev = s.prev; thresh = s.thr; diff_en = s.den; sync_clr = s.sclr;
    run_k = (fe_cnt >= 2);
    @(negedge clk);
    smp_oe = oe; smp_om = omotion; smp_done = frame_done; smp_rd = sdr_rd;
    smp_nwr = sdr_nwr; smp_pair = opair; smp_diff = odiff; smp_fm = frame_motion;
    chk("sdr_rd", sdr_rd, run_k & s.clken);
    chk("sdr_nwr", sdr_nwr, run_k);
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk("oe", oe, e.oe);            chk("ovsync", ovsync, e.ovs);
      chk("ohsync", ohsync, e.ohs);   chk("opair", opair, e.pair);
      chk("odiff", odiff, e.diff);    chk("omotion", omotion, e.om);
      chk("frame_motion", frame_motion, e.fm);
      chk("frame_done", frame_done, e.done);
    end
    // expected outputs for the next sample
    valid   = prev_stim.clken & prev_stim.ivs & prev_stim.ihs;
    ne.oe   = valid;
    ne.ovs  = prev_stim.ivs;
    ne.ohs  = prev_stim.ihs;
    ne.pair = prev_stim.run ? {prev_stim.cur, s.prev} : 16'h0;
    d = int'(prev_stim.cur) - int'(s.prev);
    if (d < 0) d = -d;
    if (prev_stim.run && s.den && valid) begin
      ne.diff = 8'(d);
      ne.om   = (d > int'(s.thr));
    end else begin
      ne.diff = 8'h0;
      ne.om   = 1'b0;
    end
    inc = cnt_m + (last_om ? 1 : 0);
    if (inc > 15) inc = 15;
    if (last_ovs && !ne.ovs) begin
      fm_m = inc; cnt_m = 0; ne.done = 1'b1;
    end else begin
      cnt_m = inc; ne.done = 1'b0;
    end
    if (s.sclr) cnt_m = 0;
    ne.fm = 4'(fm_m);
    last_om = ne.om; last_ovs = ne.ovs;
    sb_q.push_back(ne);
    // read-back sequencing model
    if (m_prev_ivs && !s.ivs) begin
      fe_total++;
      if (fe_total == 2) fe2_cyc = cyc;
    end
    if (s.sclr) fe_cnt = 0;
    else if (m_prev_ivs && !s.ivs && fe_cnt < 15) fe_cnt++;
    m_prev_ivs = s.ivs;
    if (smp_rd && first_rd_frame == 0) first_rd_frame = frame_idx;
    if (smp_nwr && !prev_smp_nwr && nwr_rise_cyc < 0) nwr_rise_cyc = cyc;
    prev_smp_nwr = smp_nwr;
    if (smp_done) begin done_cnt++; fm_at_done = smp_fm; end
    if (smp_rd) rd_hi_cnt++;
    prev_stim = s;
    prev_stim.run = run_k;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(input logic ck, input logic vs, input logic hs,
                               input logic [7:0] cur, input logic [7:0] prv);
    stim_t s;
    s = '{clken: ck, ivs: vs, ihs: hs, den: g_den, sclr: 1'b0, run: 1'b0,
          cur: cur, prev: prv, thr: g_thr};
    return s;
  endfunction

  // mode 0: random pixels and strobes; mode 1: every pixel 0x80 vs 0x00
  task automatic gen_frame(input int lines, input int len, input int mode);
    logic [7:0] pv;
    frame_idx++;
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < len; i++) begin
        pv = (mode != 0) ? 8'h00 : 8'($urandom);
        if (mode != 0) run_cycle(mk(1'b1, 1'b1, 1'b1, 8'h80, pv));
        else run_cycle(mk(($urandom_range(0, 3) != 0), 1'b1, 1'b1, 8'($urandom), pv));
      end
      for (int i = 0; i < 2; i++)
        run_cycle(mk(1'b0, 1'b1, 1'b0, 8'h80, (mode != 0) ? 8'h00 : 8'($urandom)));
    end
    for (int i = 0; i < 3; i++)
      run_cycle(mk(1'b0, 1'b0, 1'b0, 8'h00, (mode != 0) ? 8'h00 : 8'($urandom)));
  endtask

  vec_t  vecs[8];
  stim_t st;

  initial begin
    vecs[0] = '{cur: 8'h40, prev: 8'h10, thr: 8'h2F, den: 1'b1, e_diff: 8'h30, e_om: 1'b1, e_pair: 16'h4010};
    vecs[1] = '{cur: 8'h10, prev: 8'h40, thr: 8'h30, den: 1'b1, e_diff: 8'h30, e_om: 1'b0, e_pair: 16'h1040};
    vecs[2] = '{cur: 8'hFF, prev: 8'h00, thr: 8'hFE, den: 1'b1, e_diff: 8'hFF, e_om: 1'b1, e_pair: 16'hFF00};
    vecs[3] = '{cur: 8'h00, prev: 8'hFF, thr: 8'hFF, den: 1'b1, e_diff: 8'hFF, e_om: 1'b0, e_pair: 16'h00FF};
    vecs[4] = '{cur: 8'h55, prev: 8'h55, thr: 8'h00, den: 1'b1, e_diff: 8'h00, e_om: 1'b0, e_pair: 16'h5555};
    vecs[5] = '{cur: 8'h80, prev: 8'h7F, thr: 8'h00, den: 1'b1, e_diff: 8'h01, e_om: 1'b1, e_pair: 16'h807F};
    vecs[6] = '{cur: 8'h40, prev: 8'h10, thr: 8'h00, den: 1'b0, e_diff: 8'h00, e_om: 1'b0, e_pair: 16'h4010};
    vecs[7] = '{cur: 8'h31, prev: 8'h00, thr: 8'h30, den: 1'b1, e_diff: 8'h31, e_om: 1'b1, e_pair: 16'h3100};

    clken = 1'b0; ivsync = 1'b0; ihsync = 1'b0; diff_en = 1'b0; sync_clr = 1'b0;
    pix_cur = 8'h0; pix_prev = 8'h0; thresh = 8'h0;
    resetb = 1'b1;
    #2 resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetb = 1'b1;
    model_reset();

    // three frames: read-back starts after the second frame end
    for (int f = 0; f < 3; f++) gen_frame(2, 6, 0);
    chk("first_rd_frame", first_rd_frame, 3);
    chk("nwr_rise_cycle", nwr_rise_cyc, fe2_cyc + 1);

    // difference / threshold table inside one frame
    frame_idx++;
    for (int v = 0; v < 8; v++) begin
      g_thr = vecs[v].thr; g_den = vecs[v].den;
      run_cycle(mk(1'b1, 1'b1, 1'b1, vecs[v].cur, 8'($urandom)));
      run_cycle(mk(1'b0, 1'b1, 1'b1, 8'($urandom), vecs[v].prev));
      run_cycle(mk(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom)));
      chk("vec_oe", smp_oe, 1);
      chk("vec_odiff", smp_diff, vecs[v].e_diff);
      chk("vec_omotion", smp_om, vecs[v].e_om);
      chk("vec_opair", smp_pair, vecs[v].e_pair);
    end
    g_den = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle(mk(1'b0, 1'b0, 1'b0, 8'h0, 8'h0));

    // 20 moving pixels into a 4-bit counter
    g_thr = 8'h10;
    done_cnt = 0;
    gen_frame(2, 10, 1);
    chk("sat_done_pulses", done_cnt, 1);
    chk("sat_frame_motion", fm_at_done, 15);

    // sync_clr coincident with a frame end while running
    frame_idx++;
    for (int i = 0; i < 6; i++) run_cycle(mk(1'b1, 1'b1, 1'b1, 8'h80, 8'h00));
    for (int i = 0; i < 3; i++) run_cycle(mk(1'b0, 1'b1, 1'b0, 8'h80, 8'h00));
    st = mk(1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
    st.sclr = 1'b1;
    run_cycle(st);
    run_cycle(mk(1'b1, 1'b0, 1'b0, 8'h0, 8'h0));
    chk("sclr_sdr_rd", smp_rd, 0);
    chk("sclr_sdr_nwr", smp_nwr, 0);
    chk("sclr_frame_motion", smp_fm, 15);
    for (int i = 0; i < 3; i++) run_cycle(mk(1'b0, 1'b0, 1'b0, 8'h0, 8'h0));
    gen_frame(2, 6, 0);
    gen_frame(2, 6, 0);

    // asynchronous reset mid-line while running
    frame_idx++;
    for (int i = 0; i < 4; i++) run_cycle(mk(1'b1, 1'b1, 1'b1, 8'h80, 8'h00));
    resetb = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    model_reset();
    rd_hi_cnt = 0;
    for (int i = 0; i < 4; i++) run_cycle(mk(1'b1, 1'b1, 1'b1, 8'h80, 8'h00));
    for (int i = 0; i < 2; i++) run_cycle(mk(1'b0, 1'b1, 1'b0, 8'h80, 8'h00));
    for (int i = 0; i < 3; i++) run_cycle(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    gen_frame(2, 6, 1);
    chk("midrst_rd_quiet", rd_hi_cnt, 0);
    gen_frame(2, 6, 1);
    chk("midrst_rd_resumes", (rd_hi_cnt != 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
